// File: rtl/arb_pkg.sv
// Shared definitions for the SRAM-like port arbiter:
// master IDs, arbiter FSM states and transfer size codes.
package arb_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/id_fifo.sv
// In-order ID FIFO recording which master owns each in-flight request.
// Ports: clk/reset (sync, active-high), i_push/i_din, i_pop,
//        o_head (oldest entry), o_full, o_empty.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Guarded internally so a misbehaving caller cannot corrupt state.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like memory port between the IF (inst_*) and
// EXE/MEM (data_*) masters and routes responses back in order.
// Ports: clk/reset (sync, active-high); inst_* and data_* request
//        channels with addr_ok/data_ok/rdata; mem_* downstream port;
//        resp_err (sticky: response seen with nothing outstanding).
module sram_port_arbiter
    import arb_pkg::*;
#(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        resp_err
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       r_grant_q;
    logic [7:0] r_starve_cnt;
    logic       r_resp_err;
    logic       w_sel;
    logic       w_mem_req;
    logic       w_hs;
    logic       w_starved;
    logic       w_full;
    logic       w_empty;
    logic       w_head;
    logic       w_resp;

    // Inst has waited long enough to override data priority.
    assign w_starved = inst_req & (r_starve_cnt == LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = r_grant_q;
        w_mem_req   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_sel     = (data_req & ~w_starved) ? ID_DATA : ID_INST;
                w_mem_req = (inst_req | data_req) & ~w_full;
                if (w_mem_req & ~mem_addr_ok) begin
                    w_state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                w_sel     = r_grant_q;
                w_mem_req = 1'b1;
                if (mem_addr_ok) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant_q <= ID_INST;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_mem_req && !mem_addr_ok) begin
                r_grant_q <= w_sel;
            end
        end
    end

    assign w_hs      = w_mem_req & mem_addr_ok;
    assign mem_req   = w_mem_req;
    assign mem_wr    = (w_sel == ID_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (w_sel == ID_DATA) ? data_size  : inst_size;
    assign mem_wstrb = (w_sel == ID_DATA) ? data_wstrb : inst_wstrb;
    assign mem_addr  = (w_sel == ID_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (w_sel == ID_DATA) ? data_wdata : inst_wdata;

    assign inst_addr_ok = w_hs & (w_sel == ID_INST);
    assign data_addr_ok = w_hs & (w_sel == ID_DATA);

    id_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_hs),
        .i_din   (w_sel),
        .i_pop   (w_resp),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_resp       = mem_data_ok & ~w_empty;
    assign inst_data_ok = w_resp & (w_head == ID_INST);
    assign data_data_ok = w_resp & (w_head == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!inst_req || inst_addr_ok) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_err <= 1'b0;
        end else if (mem_data_ok && w_empty) begin
            r_resp_err <= 1'b1;
        end
    end

    assign resp_err = r_resp_err;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a response scoreboard.
// Inputs change 1ns after posedge; outputs are checked at negedge.
module tb_sram_port_arbiter;
    import arb_pkg::*;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        resp_err;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .OUTSTANDING  (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
        .resp_err     (resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req    = 1'b0;
        inst_wr     = 1'b0;
        inst_size   = SIZE_WORD;
        inst_wstrb  = 4'h0;
        inst_addr   = 32'h0;
        inst_wdata  = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = SIZE_WORD;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic exp_push(input logic id, input logic [31:0] rd);
        exp_t e;
        e.id    = id;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    // Drive the next expected response onto the memory side.
    task automatic resp_drive();
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            cur = sb.pop_front();
        end else begin
            cur.id    = ID_INST;
            cur.rdata = 32'hDEADBEEF;
        end
        mem_data_ok = 1'b1;
        mem_rdata   = cur.rdata;
    endtask

    task automatic resp_check();
        chk("inst_data_ok", 32'(inst_data_ok), 32'(cur.id == ID_INST));
        chk("data_data_ok", 32'(data_data_ok), 32'(cur.id == ID_DATA));
        if (cur.id == ID_INST)
            chk("inst_rdata", inst_rdata, cur.rdata);
        else
            chk("data_rdata", data_rdata, cur.rdata);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
        chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        tick();
        reset = 1'b0;

        // Single inst read.
        inst_req    = 1'b1;
        inst_addr   = 32'h1C000000;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h1C000000);
        chk("t1_inst_aok", 32'(inst_addr_ok), 32'd1);
        chk("t1_data_aok", 32'(data_addr_ok), 32'd0);
        exp_push(ID_INST, 32'h02800C0C);
        tick();
        idle_inputs();
        @(negedge clk);
        chk("t1_quiet", 32'({inst_data_ok, data_data_ok}), 32'd0);
        tick();
        resp_drive();
        @(negedge clk);
        resp_check();
        tick();
        idle_inputs();

        // Simultaneous requests: data first, then inst.
        inst_req    = 1'b1;
        inst_addr   = 32'h1C000010;
        data_req    = 1'b1;
        data_addr   = 32'h80001000;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("t2_data_aok", 32'(data_addr_ok), 32'd1);
        chk("t2_inst_aok0", 32'(inst_addr_ok), 32'd0);
        chk("t2_mem_addr_d", mem_addr, 32'h80001000);
        exp_push(ID_DATA, 32'hAAAA0000);
        tick();
        data_req = 1'b0;
        @(negedge clk);
        chk("t2_inst_aok", 32'(inst_addr_ok), 32'd1);
        chk("t2_mem_addr_i", mem_addr, 32'h1C000010);
        exp_push(ID_INST, 32'h11110000);
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            resp_drive();
            @(negedge clk);
            resp_check();
            tick();
            idle_inputs();
        end

        // Grant lock while downstream stalls.
        inst_req  = 1'b1;
        inst_addr = 32'h1C000020;
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) begin
                data_req  = 1'b1;
                data_addr = 32'h80002000;
            end
            @(negedge clk);
            chk("t3_lock_addr", mem_addr, 32'h1C000020);
            chk("t3_lock_req", 32'(mem_req), 32'd1);
            chk("t3_lock_aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
            tick();
        end
        mem_addr_ok = 1'b1;
        @(negedge clk);
        chk("t3_inst_aok", 32'(inst_addr_ok), 32'd1);
        chk("t3_addr4", mem_addr, 32'h1C000020);
        exp_push(ID_INST, 32'h33330000);
        tick();
        inst_req = 1'b0;
        @(negedge clk);
        chk("t3_data_aok", 32'(data_addr_ok), 32'd1);
        chk("t3_data_addr", mem_addr, 32'h80002000);
        exp_push(ID_DATA, 32'h44440000);
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            resp_drive();
            @(negedge clk);
            resp_check();
            tick();
            idle_inputs();
        end

        // Fill the ID FIFO with four data writes.
        data_req    = 1'b1;
        data_wr     = 1'b1;
        data_wstrb  = 4'hF;
        data_addr   = 32'h80003000;
        data_wdata  = 32'h5A5A5A5A;
        mem_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_wr_aok", 32'(data_addr_ok), 32'd1);
            chk("t4_wr_fields", {mem_wr, mem_wstrb, 27'h0},
                {1'b1, 4'hF, 27'h0});
            exp_push(ID_DATA, 32'h0 + i);
            tick();
        end
        @(negedge clk);
        chk("t4_full_req", 32'(mem_req), 32'd0);
        chk("t4_full_aok", 32'(data_addr_ok), 32'd0);
        tick();
        resp_drive();
        @(negedge clk);
        resp_check();
        chk("t4_no_bypass", 32'(mem_req), 32'd0);
        tick();
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk("t4_5th_req", 32'(mem_req), 32'd1);
        chk("t4_5th_aok", 32'(data_addr_ok), 32'd1);
        exp_push(ID_DATA, 32'h00000004);
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            resp_drive();
            @(negedge clk);
            resp_check();
            tick();
            idle_inputs();
        end

        // Starvation: inst forced through on the 9th waiting cycle.
        inst_req    = 1'b1;
        inst_addr   = 32'h1C000040;
        data_req    = 1'b1;
        data_addr   = 32'h80004000;
        mem_addr_ok = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) inst_req = 1'b0;
            if (k >= 2) resp_drive();
            @(negedge clk);
            if (k >= 2) resp_check();
            if (k == 9) begin
                chk("t5_inst_aok9", 32'(inst_addr_ok), 32'd1);
                chk("t5_data_aok9", 32'(data_addr_ok), 32'd0);
                exp_push(ID_INST, 32'hC0DE0000 + k);
            end else begin
                chk("t5_data_aok", 32'(data_addr_ok), 32'd1);
                chk("t5_inst_aok", 32'(inst_addr_ok), 32'd0);
                exp_push(ID_DATA, 32'hD0000000 + k);
            end
            tick();
            mem_data_ok = 1'b0;
        end
        idle_inputs();
        resp_drive();
        @(negedge clk);
        resp_check();
        tick();
        idle_inputs();

        // Response with nothing outstanding.
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hBAD0BAD0;
        @(negedge clk);
        chk("t6_no_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        chk("t6_err_pre", 32'(resp_err), 32'd0);
        tick();
        mem_data_ok = 1'b0;
        @(negedge clk);
        chk("t6_err_set", 32'(resp_err), 32'd1);
        tick();
        tick();
        @(negedge clk);
        chk("t6_err_hold", 32'(resp_err), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_err_clr", 32'(resp_err), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch master (inst_*) and the data master (inst_* from IF, data_* from EXE/MEM).
- Arbitrates request handshakes and locks the grant until address acceptance.
- Tracks outstanding transactions in an in-order ID FIFO and routes each response (data_ok/rdata) back to the master that issued it.
- Sits between the pipeline stages and the AXI bridge / memory-side SRAM-like interface.

Parameters:
- OUTSTANDING, 4, max in-flight transactions; power of 2, 2..16
- STARVE_LIMIT, 8, consecutive cycles inst may be denied before it gets forced priority; 1..255

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  IF request
- inst_wr  in  1  IF write (normally 0)
- inst_size  in  2  0=byte 1=half 2=word
- inst_wstrb  in  4  byte write strobes
- inst_addr  in  32  address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  IF request accepted
- inst_data_ok  out  1  IF response valid
- inst_rdata  out  32  IF read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master, same meaning as inst_*
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- mem_req  out  1  downstream request
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/4/32/32  muxed request fields
- mem_addr_ok  in  1  downstream accept
- mem_data_ok  in  1  downstream response
- mem_rdata  in  32  downstream read data
- resp_err  out  1  sticky: mem_data_ok received with FIFO empty

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE, FIFO empty (rd_ptr=wr_ptr=count=0), starve_cnt=0, resp_err=0. All outputs deassert combinationally from this state: mem_req, all addr_ok and data_ok=0.
- Protocol: masters hold req and all fields stable from assertion until addr_ok. Handshake = mem_req & mem_addr_ok.
- FSM IDLE:
  - sel = DATA if data_req & !(inst_req & starve_cnt==STARVE_LIMIT); else INST if inst_req.
  - mem_req = (inst_req|data_req) & !fifo_full. Fields mux from sel.
  - Handshake in the same cycle: stay IDLE.
  - mem_req=1 without mem_addr_ok: latch sel into grant_q and go LOCKED.
- FSM LOCKED: grant fixed to grant_q regardless of new requests; mem_req=1. Return to IDLE on mem_addr_ok.
- addr_ok routing: inst_addr_ok = mem_addr_ok & mem_req & grant==INST; data_addr_ok likewise. Zero cycles of added latency.
- FIFO full:
  - mem_req masked in IDLE even if a pop happens the same cycle (no bypass).
  - LOCKED cannot occur while full, since entry to LOCKED requires a request issued while not full.
- Push: on handshake, push the 1-bit master ID (0=INST, 1=DATA). Pop: on mem_data_ok.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo OUTSTANDING. Count is $clog2(OUTSTANDING)+1 bits.
- Response routing (combinational):
  - inst_data_ok = mem_data_ok & !empty & head==INST; data_data_ok likewise.
  - rdata passed to both masters unmasked.
  - mem_data_ok while empty: no pop, no data_ok, resp_err <= 1 until reset.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle inst_req=1 and inst is not handshaken.
  - Clears on inst handshake or when inst_req=0.
- Reset mid-transaction: all in-flight state dropped. Responses arriving after reset set resp_err (empty FIFO). The downstream must be reset together with this block.

Decomposition:
- Shared package `arb_pkg`: master ID constants (ID_INST=0, ID_DATA=1), FSM state encoding (IDLE=0, LOCKED=1), size encodings.
- One sub-module: `id_fifo` (parameterised depth, width 1; push/pop/full/empty/head), reusable for later AXI bridge ID tracking.

Test Plan:
- Reset, then a single inst read at addr 0x1C000000, mem_addr_ok the same cycle, mem_data_ok 2 cycles later with rdata 0x02800C0C -> inst_addr_ok at cycle 0, inst_data_ok + rdata at cycle 2, data_* silent.
- inst_req and data_req asserted in the same cycle, mem_addr_ok always 1 -> data granted first, inst granted the next cycle. Responses returned in order D then I with rdata 0xAAAA0000/0x11110000 are routed correctly.
- mem_addr_ok held 0 for 3 cycles while inst is pending; data_req rises in cycle 1 -> mem_addr stays the inst address throughout, inst_addr_ok on the 4th cycle, data granted next.
- OUTSTANDING=4: 4 data writes (wstrb 0xF) accepted with no data_ok -> 5th request sees mem_req=0. mem_data_ok for the 1st response -> 5th request issued the following cycle.
- data_req held continuously, inst_req held, STARVE_LIMIT=8 -> inst granted exactly on the 9th cycle of waiting, starve_cnt cleared, data resumes.
- mem_data_ok pulse with FIFO empty -> no data_ok output, resp_err=1 and held. Reset -> resp_err=0.
